// File: rtl/fpu.sv
// fpu: multi-cycle adder for the 32-bit custom float format
//   sign[31], exp[30:25] (bias 31), frac[24:0] with hidden 1.
// Ports:
//   clock, reset            rising-edge clock, sync active-high reset
//   op_A_in, op_B_in [31:0] operands, captured in LOAD
//   data_out        [31:0]  registered sum, held in DONE
//   status_out      [3:0]   one-hot {INEXACT,UNDERFLOW,OVERFLOW,EXACT}
module fpu (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] op_A_in,
    input  logic [31:0] op_B_in,
    output logic [31:0] data_out,
    output logic [3:0]  status_out
);

    typedef enum logic [2:0] {
        S_LOAD, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
    } state_t;

    state_t state_q, state_d;

    // LOAD registers
    logic        sa_q, sb_q;
    logic [5:0]  ea_q, eb_q;
    logic [25:0] ma_q, mb_q;
    logic        uf_pend_q;

    // ALIGN registers: working word is {hidden, frac[24:0], g1, g0, sticky}
    logic        sx_q, sy_q;
    logic [5:0]  ex_q;
    logic [28:0] xw_q, yw_q;

    // ADD registers
    logic               rs_q;
    logic signed [7:0]  re_q;
    logic [29:0]        sum_q;

    // NORM registers
    logic signed [7:0]  ne_q;
    logic [28:0]        nm_q;

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_LOAD:  state_d = S_ALIGN;
            S_ALIGN: state_d = S_ADD;
            S_ADD:   state_d = S_NORM;
            S_NORM:  state_d = S_ROUND;
            S_ROUND: state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_LOAD;
        else       state_q <= state_d;
    end

    // ---------------- ALIGN datapath ----------------
    logic        a_ge_b;
    logic        x_s, y_s;
    logic [5:0]  x_e, y_e, dexp;
    logic [25:0] x_m, y_m;
    logic [55:0] y_sh;
    logic [28:0] y_al;

    always_comb begin
        a_ge_b = {ea_q, ma_q} >= {eb_q, mb_q};
        x_s    = a_ge_b ? sa_q : sb_q;
        y_s    = a_ge_b ? sb_q : sa_q;
        x_e    = a_ge_b ? ea_q : eb_q;
        y_e    = a_ge_b ? eb_q : ea_q;
        x_m    = a_ge_b ? ma_q : mb_q;
        y_m    = a_ge_b ? mb_q : ma_q;
        dexp   = x_e - y_e;
        // Low 28 bits of the wide shift are everything pushed past the guards
        y_sh   = {y_m, 2'b00, 28'd0} >> dexp;
        if (dexp >= 6'd28)
            y_al = {28'd0, |y_m};
        else
            y_al = {y_sh[55:28], |y_sh[27:0]};
    end

    // ---------------- ADD datapath ----------------
    logic [29:0] sum_c;

    always_comb begin
        if (sx_q == sy_q)
            sum_c = {1'b0, xw_q} + {1'b0, yw_q};
        else
            sum_c = {1'b0, xw_q} - {1'b0, yw_q};
    end

    // ---------------- NORM datapath ----------------
    logic [4:0] lzc;
    logic       found;

    always_comb begin
        lzc   = 5'd0;
        found = 1'b0;
        for (int i = 28; i >= 0; i--) begin
            if (!found) begin
                if (sum_q[i]) found = 1'b1;
                else          lzc   = lzc + 5'd1;
            end
        end
    end

    // ---------------- ROUND datapath ----------------
    logic        r_ovf, r_unf, r_inx, r_zero;
    logic [31:0] r_data;
    logic [3:0]  r_stat;

    always_comb begin
        r_zero = (nm_q == 29'd0);
        r_inx  = |nm_q[2:0];
        r_ovf  = !r_zero && (ne_q > 8'sd63);
        r_unf  = !r_zero && (ne_q < 8'sd1);
        if (r_ovf)
            r_data = {rs_q, 6'h3F, 25'd0};
        else if (r_unf)
            r_data = {rs_q, 31'd0};
        else if (r_zero)
            r_data = 32'd0;
        else
            r_data = {rs_q, ne_q[5:0], nm_q[27:3]};
        if (r_ovf)
            r_stat = 4'b0010;
        else if (r_unf || uf_pend_q)
            r_stat = 4'b0100;
        else if (r_inx)
            r_stat = 4'b1000;
        else
            r_stat = 4'b0001;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            ea_q       <= 6'd0;
            eb_q       <= 6'd0;
            ma_q       <= 26'd0;
            mb_q       <= 26'd0;
            uf_pend_q  <= 1'b0;
            sx_q       <= 1'b0;
            sy_q       <= 1'b0;
            ex_q       <= 6'd0;
            xw_q       <= 29'd0;
            yw_q       <= 29'd0;
            rs_q       <= 1'b0;
            re_q       <= 8'sd0;
            sum_q      <= 30'd0;
            ne_q       <= 8'sd0;
            nm_q       <= 29'd0;
            data_out   <= 32'd0;
            status_out <= 4'd0;
        end else begin
            unique case (state_q)
                S_LOAD: begin
                    sa_q <= op_A_in[31];
                    sb_q <= op_B_in[31];
                    ea_q <= op_A_in[30:25];
                    eb_q <= op_B_in[30:25];
                    // Zero exponent flushes: no hidden bit, fraction dropped
                    ma_q <= (op_A_in[30:25] != 6'd0) ?
                            {1'b1, op_A_in[24:0]} : 26'd0;
                    mb_q <= (op_B_in[30:25] != 6'd0) ?
                            {1'b1, op_B_in[24:0]} : 26'd0;
                    uf_pend_q <=
                        ((op_A_in[30:25] == 6'd0) && (op_A_in[24:0] != 25'd0)) ||
                        ((op_B_in[30:25] == 6'd0) && (op_B_in[24:0] != 25'd0));
                end
                S_ALIGN: begin
                    sx_q <= x_s;
                    sy_q <= y_s;
                    ex_q <= x_e;
                    xw_q <= {x_m, 3'b000};
                    yw_q <= y_al;
                end
                S_ADD: begin
                    sum_q <= sum_c;
                    if (sum_c == 30'd0) begin
                        rs_q <= 1'b0;
                        re_q <= 8'sd0;
                    end else begin
                        rs_q <= sx_q;
                        re_q <= $signed({2'b00, ex_q});
                    end
                end
                S_NORM: begin
                    if (sum_q[29]) begin
                        // Carry-out: bit shifted off folds into sticky
                        nm_q <= {sum_q[29:2], sum_q[1] | sum_q[0]};
                        ne_q <= re_q + 8'sd1;
                    end else if (sum_q == 30'd0) begin
                        nm_q <= 29'd0;
                        ne_q <= 8'sd0;
                    end else begin
                        nm_q <= sum_q[28:0] << lzc;
                        ne_q <= re_q - $signed({3'b000, lzc});
                    end
                end
                S_ROUND: begin
                    data_out   <= r_data;
                    status_out <= r_stat;
                end
                S_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu.sv
// tb_fpu: directed vectors for fpu with a queue scoreboard
//   stimulus pushes expected results; a negedge monitor pops and compares.
module tb_fpu;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] op_A_in = 32'd0;
    logic [31:0] op_B_in = 32'd0;
    logic [31:0] data_out;
    logic [3:0]  status_out;

    fpu dut (
        .clock      (clock),
        .reset      (reset),
        .op_A_in    (op_A_in),
        .op_B_in    (op_B_in),
        .data_out   (data_out),
        .status_out (status_out)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  s;
    } exp_t;

    exp_t sb_q[$];
    exp_t held;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   rcyc   = 0;

    // Edges since reset dropped / edges spent in reset
    always @(posedge clock) begin
        if (reset) begin
            cyc  <= 0;
            rcyc <= rcyc + 1;
        end else begin
            cyc  <= cyc + 1;
            rcyc <= 0;
        end
    end

    // Monitor
    always @(negedge clock) begin
        if (reset && rcyc == 1) begin
            n_chk++;
            if (data_out !== 32'd0 || status_out !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_clear: got %h/%b, want 00000000/0000",
                         data_out, status_out);
            end
        end else if (!reset && cyc == 4) begin
            n_chk++;
            if (data_out !== 32'd0 || status_out !== 4'd0) begin
                n_fail++;
                $display("FAIL early_out edge4: got %h/%b, want 00000000/0000",
                         data_out, status_out);
            end
        end else if (!reset && cyc == 5) begin
            n_chk++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL result: got %h/%b, no expected entry",
                         data_out, status_out);
            end else begin
                held = sb_q.pop_front();
                if (data_out !== held.d || status_out !== held.s) begin
                    n_fail++;
                    $display("FAIL result: got %h/%b, want %h/%b",
                             data_out, status_out, held.d, held.s);
                end
            end
        end else if (!reset && cyc == 8) begin
            n_chk++;
            if (data_out !== held.d || status_out !== held.s) begin
                n_fail++;
                $display("FAIL done_hold: got %h/%b, want %h/%b",
                         data_out, status_out, held.d, held.s);
            end
        end
    end

    task automatic run(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        op_A_in = a;
        op_B_in = b;
        e.d = d;
        e.s = s;
        sb_q.push_back(e);
        reset = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        // Operand changes in DONE must not disturb the held result
        op_A_in = ~a;
        op_B_in = b ^ 32'h5A5A5A5A;
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic run_abort(input logic [31:0] a, input logic [31:0] b);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        op_A_in = a;
        op_B_in = b;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clock);
        #1;
        run(32'hBE000000, 32'hBE000000, 32'hC0000000, 4'b0001);
        run(32'h40000000, 32'hC2000000, 32'hC0000000, 4'b0001);
        run(32'h3E000000, 32'hBE000000, 32'h00000000, 4'b0001);
        run(32'h3F000000, 32'h40400000, 32'h41C00000, 4'b0001);
        run(32'h3F000000, 32'h3C000000, 32'h40000000, 4'b0001);
        run(32'h7F000000, 32'h7F000000, 32'h7E000000, 4'b0010);
        run(32'hFF000000, 32'hFF000000, 32'hFE000000, 4'b0010);
        run(32'h00000002, 32'h80000000, 32'h00000000, 4'b0100);
        run(32'h40000001, 32'h40000000, 32'h42000000, 4'b1000);
        run(32'h03000000, 32'h82000000, 32'h00000000, 4'b0100);
        run(32'h3E000000, 32'h06000000, 32'h3E000000, 4'b1000);
        run(32'h3E000000, 32'h86000000, 32'h3DFFFFFF, 4'b1000);
        run(32'h3F000000, 32'h00000000, 32'h3F000000, 4'b0001);
        run(32'h00000005, 32'h3E000000, 32'h3E000000, 4'b0100);
        run(32'h40000000, 32'h3E000000, 32'h41000000, 4'b0001);
        run(32'h7E000000, 32'h00000000, 32'h7E000000, 4'b0001);
        run_abort(32'h7F000000, 32'h7F000000);
        run(32'h3F000000, 32'h40400000, 32'h41C00000, 4'b0001);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_chk++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left, want 0",
                     sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
